// File: rtl/bus_tmo.sv
// Bus timeout monitor: synthesises a zero-data ack for CPU accesses that no slave
// acknowledges within a programmable number of cycles, and records the faulting access.
module bus_tmo #(
    parameter int unsigned default_limit = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    // CPU side and slave multiplexers
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [21:0] cpu_addr,
    input  logic        slv_ack,
    input  logic [31:0] slv_din,
    output logic        cpu_ack,
    output logic [31:0] cpu_din,
    output logic        trig,
    // own two-register IO window
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack
);

    localparam logic [15:0] LIMIT_RST = 16'(default_limit);
    localparam logic [15:0] LIMIT_MIN = 16'd2;

    logic [15:0] cnt;
    logic [15:0] limit;
    logic [21:0] prev_addr;
    logic        en;
    logic        flag;
    logic        err_we;
    logic [23:0] err_addr;
    logic [7:0]  err_cnt;

    logic tmo;
    logic cnt_clr;
    logic wr_ctrl;
    logic wr_limit;

    // A real slave ack in the same cycle as the limit match always wins.
    assign tmo      = en & cpu_stb & ~slv_ack & (cnt == limit);
    assign cnt_clr  = ~cpu_stb | slv_ack | tmo | (cpu_addr != prev_addr) | ~en;

    assign cpu_ack  = slv_ack | tmo;
    assign cpu_din  = tmo ? 32'h0 : slv_din;

    assign wr_ctrl  = stb & we & ~addr;
    assign wr_limit = stb & we & addr;
    assign ack      = stb;

    always_comb begin
        data_out = 32'h0;
        if (stb) begin
            if (addr)
                data_out = {err_cnt, 8'h00, limit};
            else
                data_out = {flag, en, err_we, 5'b00000, err_addr};
        end
    end

    // NOTE: all state here is plain registers, so every bit gets an async reset value;
    // sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 16'h0;
            limit     <= LIMIT_RST;
            prev_addr <= 22'h0;
            en        <= 1'b1;
            flag      <= 1'b0;
            err_we    <= 1'b0;
            err_addr  <= 24'h0;
            err_cnt   <= 8'h0;
            trig      <= 1'b0;
        end else begin
            prev_addr <= cpu_addr;
            cnt       <= cnt_clr ? 16'h0 : cnt + 16'd1;
            trig      <= tmo;

            if (tmo) begin
                err_addr <= {cpu_addr, 2'b00};
                err_we   <= cpu_we;
                flag     <= 1'b1;
                if (err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end

            // A software clear issued in the same cycle as a timeout takes precedence.
            if (wr_ctrl) begin
                en <= data_in[1];
                if (data_in[0]) begin
                    flag     <= 1'b0;
                    err_cnt  <= 8'h0;
                    err_addr <= 24'h0;
                    err_we   <= 1'b0;
                end
            end

            if (wr_limit)
                limit <= (data_in[15:0] < LIMIT_MIN) ? LIMIT_MIN : data_in[15:0];
        end
    end

endmodule

// File: tb/tb_bus_tmo.sv
// Self-checking bench for bus_tmo: a per-cycle reference model of the timeout rules
// plus directed scenarios with hand-computed expectations.
module tb_bus_tmo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_stb, cpu_we, slv_ack;
    logic [21:0] cpu_addr;
    logic [31:0] slv_din;
    logic        cpu_ack, trig;
    logic [31:0] cpu_din;
    logic        stb, we, addr, ack;
    logic [31:0] data_in, data_out;

    int passed = 0;
    int total  = 0;

    bus_tmo #(.default_limit(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .slv_ack(slv_ack), .slv_din(slv_din),
        .cpu_ack(cpu_ack), .cpu_din(cpu_din), .trig(trig),
        .stb(stb), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .ack(ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // m_stall: how many cycles the current access has been pending on the same address.
    int          m_stall;
    int          m_limit;
    int          m_err_cnt;
    logic [21:0] m_prev;
    logic        m_en, m_flag, m_err_we, m_trig;
    logic [23:0] m_err_addr;
    int          n_ack_seen = 0;
    int          n_trig_seen = 0;

    task automatic model_reset();
        m_stall = 0; m_limit = 1024; m_err_cnt = 0; m_prev = '0;
        m_en = 1'b1; m_flag = 1'b0; m_err_we = 1'b0; m_trig = 1'b0; m_err_addr = '0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        logic        m_tmo, m_clr;
        logic [31:0] exp_dout;
        if (!rst_n) model_reset();
        m_tmo = rst_n && m_en && cpu_stb && !slv_ack && (m_stall == m_limit);
        exp_dout = !stb ? 32'h0 :
                   addr ? {8'(m_err_cnt), 8'h00, 16'(m_limit)}
                        : {m_flag, m_en, m_err_we, 5'b0, m_err_addr};
        check("cpu_ack",  {31'b0, cpu_ack}, {31'b0, slv_ack | m_tmo});
        check("cpu_din",  cpu_din, m_tmo ? 32'h0 : slv_din);
        check("trig",     {31'b0, trig}, {31'b0, m_trig});
        check("reg_ack",  {31'b0, ack}, {31'b0, stb});
        check("data_out", data_out, exp_dout);
        if (cpu_ack) n_ack_seen++;
        if (trig)    n_trig_seen++;
        if (rst_n) begin
            m_clr   = !cpu_stb || slv_ack || m_tmo || (cpu_addr != m_prev) || !m_en;
            m_stall = m_clr ? 0 : m_stall + 1;
            m_prev  = cpu_addr;
            m_trig  = m_tmo;
            if (m_tmo) begin
                m_err_addr = {cpu_addr, 2'b00};
                m_err_we   = cpu_we;
                m_flag     = 1'b1;
                if (m_err_cnt < 255) m_err_cnt++;
            end
            if (stb && we && !addr) begin
                m_en = data_in[1];
                if (data_in[0]) begin
                    m_flag = 1'b0; m_err_cnt = 0; m_err_addr = '0; m_err_we = 1'b0;
                end
            end
            if (stb && we && addr)
                m_limit = (data_in[15:0] < 16'd2) ? 2 : int'(data_in[15:0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d;
        tick();
        stb = 1'b0; we = 1'b0; data_in = '0;
    endtask

    task automatic reg_read(input logic a, output logic [31:0] d);
        stb = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        d = data_out;
        tick();
        stb = 1'b0;
    endtask

    // One CPU access; cycle 0 is the first cycle with cpu_stb high. ack_at < 0 means
    // the slave never answers. Returns the cycles of cpu_ack and of trig (-1 if none).
    task automatic run_access(input logic [21:0] a, input logic w, input int ack_at,
                              output int ack_cyc, output logic [31:0] din,
                              output int trig_cyc);
        int k;
        ack_cyc = -1; trig_cyc = -1; din = 'x;
        cpu_addr = a; cpu_we = w; cpu_stb = 1'b0; slv_ack = 1'b0;
        tick();
        cpu_stb = 1'b1;
        for (k = 0; k < 200; k++) begin
            slv_ack = (k == ack_at);
            slv_din = 32'hA5A5_0000 | k;
            @(negedge clk);
            if (trig && trig_cyc < 0) trig_cyc = k;
            if (cpu_ack) begin
                ack_cyc = k;
                din = cpu_din;
                tick();
                break;
            end
            tick();
        end
        cpu_stb = 1'b0; slv_ack = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            if (trig && trig_cyc < 0) trig_cyc = ack_cyc + j;
            tick();
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [31:0] rd, din;
        int ack_cyc, trig_cyc, n_trig0, n_ack0;

        rst_n = 1'b0;
        cpu_stb = 0; cpu_we = 0; cpu_addr = '0; slv_ack = 0; slv_din = '0;
        stb = 0; we = 0; addr = 0; data_in = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        reg_read(1'b0, rd); check("reset_reg0", rd, 32'h4000_0000);
        reg_read(1'b1, rd); check("reset_reg1", rd, 32'h0000_0400);
        reg_write(1'b1, 32'h0000_0010);
        reg_read(1'b1, rd); check("limit16_reg1", rd, 32'h0000_0010);

        // Normal access acked by the slave in cycle 3.
        n_trig0 = n_trig_seen;
        run_access(22'h000100, 1'b0, 3, ack_cyc, din, trig_cyc);
        check("normal_ack_cyc", ack_cyc, 3);
        check("normal_din", din, 32'hA5A5_0003);
        check("normal_trig", trig_cyc, -1);
        check("normal_trig_cnt", n_trig_seen - n_trig0, 0);
        reg_read(1'b0, rd); check("normal_reg0", rd, 32'h4000_0000);

        // Stalled read: synthesised ack in cycle 16, trig in cycle 17.
        n_trig0 = n_trig_seen;
        run_access(22'h3FFFC0, 1'b0, -1, ack_cyc, din, trig_cyc);
        check("stall_ack_cyc", ack_cyc, 16);
        check("stall_din", din, 32'h0);
        check("stall_trig_cyc", trig_cyc, 17);
        check("stall_trig_cnt", n_trig_seen - n_trig0, 1);
        reg_read(1'b0, rd); check("stall_reg0", rd, 32'hC0FF_FF00);
        reg_read(1'b1, rd); check("stall_reg1", rd, 32'h0100_0010);

        // Race: slave ack arrives exactly when cnt reaches the limit.
        n_ack0 = n_ack_seen; n_trig0 = n_trig_seen;
        run_access(22'h000123, 1'b1, 16, ack_cyc, din, trig_cyc);
        check("race_ack_cyc", ack_cyc, 16);
        check("race_din", din, 32'hA5A5_0010);
        check("race_trig", trig_cyc, -1);
        check("race_ack_cnt", n_ack_seen - n_ack0, 1);
        reg_read(1'b1, rd); check("race_reg1", rd, 32'h0100_0010);
        reg_read(1'b0, rd); check("race_reg0", rd, 32'hC0FF_FF00);

        // Clear and limit clamp.
        reg_write(1'b0, 32'h0000_0003);
        reg_read(1'b0, rd); check("clear_reg0", rd, 32'h4000_0000);
        reg_read(1'b1, rd); check("clear_reg1", rd, 32'h0000_0010);
        reg_write(1'b1, 32'h0000_0001);
        reg_read(1'b1, rd); check("clamp_reg1", rd, 32'h0000_0002);
        run_access(22'h000200, 1'b1, -1, ack_cyc, din, trig_cyc);
        check("clamp_ack_cyc", ack_cyc, 2);
        check("clamp_trig_cyc", trig_cyc, 3);
        reg_read(1'b0, rd); check("clamp_reg0_we", rd, 32'hE000_0800);

        // 300 back-to-back stalled accesses at limit 2: one timeout every 3 cycles.
        reg_write(1'b0, 32'h0000_0003);
        n_ack0 = n_ack_seen; n_trig0 = n_trig_seen;
        cpu_addr = 22'h000040; cpu_we = 1'b0; cpu_stb = 1'b0;
        tick();
        cpu_stb = 1'b1;
        repeat (900) tick();
        cpu_stb = 1'b0;
        repeat (3) tick();
        check("sat_ack_cnt", n_ack_seen - n_ack0, 300);
        check("sat_trig_cnt", n_trig_seen - n_trig0, 300);
        reg_read(1'b1, rd); check("sat_reg1", rd, 32'hFF00_0002);

        // Disabled monitor: a long stall produces nothing; then reset mid-stall.
        reg_write(1'b0, 32'h0000_0000);
        n_ack0 = n_ack_seen; n_trig0 = n_trig_seen;
        cpu_addr = 22'h0AAAAA; cpu_we = 1'b1; cpu_stb = 1'b0;
        tick();
        cpu_stb = 1'b1;
        repeat (100) tick();
        check("dis_ack_cnt", n_ack_seen - n_ack0, 0);
        check("dis_trig_cnt", n_trig_seen - n_trig0, 0);
        reg_write(1'b0, 32'h0000_0002);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_cpu_ack", {31'b0, cpu_ack}, 32'h0);
        check("rst_trig", {31'b0, trig}, 32'h0);
        tick();
        cpu_stb = 1'b0;
        reg_read(1'b0, rd); check("rst_reg0", rd, 32'h4000_0000);
        reg_read(1'b1, rd); check("rst_reg1", rd, 32'h0000_0400);
        rst_n = 1'b1;
        repeat (3) tick();
        reg_read(1'b1, rd); check("post_rst_reg1", rd, 32'h0000_0400);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
